sdram_arb: RTL and testbench

SDRAM_ARB -- requirements
Module: sdram_arb

---
 rtl/sdram_arb_pkg.sv | 22 ++
 rtl/sdram_arb_prio.sv | 38 +++
 rtl/sdram_arb.sv | 218 +++++++++++++++++++++
 tb/tb_sdram_arb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM arbiter
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT,
        ST_DONE
    } arb_state_e;

    typedef logic [1:0] client_t;

    localparam client_t CL_SPR = 2'd0;
    localparam client_t CL_FIX = 2'd1;
    localparam client_t CL_CPU = 2'd2;

    localparam int ADDR_W = 25;
    localparam int BUS_W  = 64;
    localparam int CPU_W  = 16;

endpackage

// File: rtl/sdram_arb_prio.sv
// rtl/sdram_arb_prio.sv - combinational winner selection with CPU starvation override
//
// Ports:
//   spr_req_i, fix_req_i, cpu_req_i : sampled client requests
//   starve_cnt_i                    : cycles the CPU has waited (saturating)
//   grant_o                         : at least one client is requesting
//   winner_o                        : selected client index
module sdram_arb_prio
    import sdram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 64,
    parameter int CNT_W      = 7
) (
    input  logic             spr_req_i,
    input  logic             fix_req_i,
    input  logic             cpu_req_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output logic             grant_o,
    output client_t          winner_o
);

    logic cpu_starved;

    always_comb begin
        cpu_starved = cpu_req_i && (starve_cnt_i == CNT_W'(STARVE_MAX));
        grant_o     = spr_req_i | fix_req_i | cpu_req_i;
        // Falls through to CPU when neither video client asks.
        winner_o    = CL_CPU;
        if (cpu_starved) begin
            winner_o = CL_CPU;
        end else if (spr_req_i) begin
            winner_o = CL_SPR;
        end else if (fix_req_i) begin
            winner_o = CL_FIX;
        end
    end

endmodule

// File: rtl/sdram_arb.sv
// rtl/sdram_arb.sv - three-client SDRAM request arbiter with starvation guard and timeout
//
// Ports:
//   clk, nRESET                         : clock, async active-low reset
//   spr_req/spr_addr -> spr_ack/spr_data: sprite client, 4-word burst read
//   fix_req/fix_addr -> fix_ack/fix_data: fix/ADPCM client, 4-word burst read
//   cpu_req/cpu_we/cpu_addr/cpu_din/cpu_wtbt -> cpu_ack/cpu_dout : CPU single word
//   sd_addr/sd_din/sd_wtbt/sd_rd/sd_we  : request side of SDRAM controller
//   sd_dout/sd_ready_first/sd_ready_fourth : response side of SDRAM controller
//   err                                 : sticky timeout flag
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              spr_ack,
    output logic [BUS_W-1:0]  spr_data,
    input  logic              fix_req,
    input  logic [ADDR_W-1:0] fix_addr,
    output logic              fix_ack,
    output logic [BUS_W-1:0]  fix_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [CPU_W-1:0]  cpu_din,
    input  logic [1:0]        cpu_wtbt,
    output logic              cpu_ack,
    output logic [CPU_W-1:0]  cpu_dout,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [CPU_W-1:0]  sd_din,
    output logic [1:0]        sd_wtbt,
    output logic              sd_rd,
    output logic              sd_we,
    input  logic [BUS_W-1:0]  sd_dout,
    input  logic              sd_ready_first,
    input  logic              sd_ready_fourth,
    output logic              err
);

    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q;
    client_t           client_q;
    logic              we_q;
    logic              guard_q;
    logic              start_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] sd_addr_q;
    logic [CPU_W-1:0]  sd_din_q;
    logic [1:0]        sd_wtbt_q;
    logic              sd_rd_q, sd_we_q;
    logic              spr_ack_q, fix_ack_q, cpu_ack_q;
    logic [BUS_W-1:0]  spr_data_q, fix_data_q;
    logic [CPU_W-1:0]  cpu_dout_q;
    logic              err_q;

    logic              any_req;
    client_t           winner;
    logic              grant_go;
    logic              cpu_busy;
    logic              xfer_ready;
    logic [ADDR_W-1:0] win_addr;
    logic              win_we;
    logic [CPU_W-1:0]  win_din;
    logic [1:0]        win_wtbt;

    sdram_arb_prio #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_prio (
        .spr_req_i    (spr_req),
        .fix_req_i    (fix_req),
        .cpu_req_i    (cpu_req),
        .starve_cnt_i (starve_cnt_q),
        .grant_o      (any_req),
        .winner_o     (winner)
    );

    // start_q keeps the first edge after reset release grant-free.
    assign grant_go   = start_q && (state_q == ST_IDLE) && any_req;
    assign cpu_busy   = (state_q != ST_IDLE) && (client_q == CL_CPU);
    // Reads finish on the fourth word, writes on the first.
    assign xfer_ready = we_q ? sd_ready_first : sd_ready_fourth;

    // Read-only clients present a full-width read with no write data.
    always_comb begin
        win_addr = spr_addr;
        win_we   = 1'b0;
        win_din  = '0;
        win_wtbt = 2'b11;
        case (winner)
            CL_FIX: win_addr = fix_addr;
            CL_CPU: begin
                win_addr = cpu_addr;
                win_we   = cpu_we;
                win_din  = cpu_din;
                win_wtbt = cpu_wtbt;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_go && (winner == CL_CPU)) begin
            starve_cnt_d = '0;
        end else if (cpu_req && !cpu_busy && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= ST_IDLE;
            client_q     <= CL_SPR;
            we_q         <= 1'b0;
            guard_q      <= 1'b0;
            start_q      <= 1'b0;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            sd_addr_q    <= '0;
            sd_din_q     <= '0;
            sd_wtbt_q    <= '0;
            sd_rd_q      <= 1'b0;
            sd_we_q      <= 1'b0;
            spr_ack_q    <= 1'b0;
            fix_ack_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            spr_data_q   <= '0;
            fix_data_q   <= '0;
            cpu_dout_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            start_q      <= 1'b1;
            starve_cnt_q <= starve_cnt_d;
            spr_ack_q    <= 1'b0;
            fix_ack_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_go) begin
                        client_q  <= winner;
                        we_q      <= win_we;
                        sd_addr_q <= win_addr;
                        sd_din_q  <= win_din;
                        sd_wtbt_q <= win_wtbt;
                        sd_rd_q   <= !win_we;
                        sd_we_q   <= win_we;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    sd_rd_q <= 1'b0;
                    sd_we_q <= 1'b0;
                    guard_q <= 1'b0;
                    state_q <= ST_GUARD;
                end
                ST_GUARD: begin
                    // Ready is ignored here: the controller drops it one
                    // registered stage after seeing the request.
                    guard_q <= 1'b1;
                    if (guard_q) begin
                        wait_cnt_q <= '0;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (xfer_ready || (wait_cnt_q == WAIT_W'(TIMEOUT))) begin
                        if (!xfer_ready) begin
                            err_q <= 1'b1;
                        end
                        case (client_q)
                            CL_SPR: begin
                                spr_ack_q  <= 1'b1;
                                spr_data_q <= sd_dout;
                            end
                            CL_FIX: begin
                                fix_ack_q  <= 1'b1;
                                fix_data_q <= sd_dout;
                            end
                            CL_CPU: begin
                                cpu_ack_q  <= 1'b1;
                                cpu_dout_q <= sd_dout[63:48];
                            end
                            default: ;
                        endcase
                        state_q <= ST_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sd_addr  = sd_addr_q;
    assign sd_din   = sd_din_q;
    assign sd_wtbt  = sd_wtbt_q;
    assign sd_rd    = sd_rd_q;
    assign sd_we    = sd_we_q;
    assign spr_ack  = spr_ack_q;
    assign fix_ack  = fix_ack_q;
    assign cpu_ack  = cpu_ack_q;
    assign spr_data = spr_data_q;
    assign fix_data = fix_data_q;
    assign cpu_dout = cpu_dout_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sdram_arb.sv
// tb/tb_sdram_arb.sv - self-checking bench for sdram_arb with controller model and scoreboard
module tb_sdram_arb;
    import sdram_arb_pkg::*;

    localparam int SM   = 16;
    localparam int TO   = 30;
    localparam int LMAX = 4;
    localparam logic [63:0] NEVER_DATA = 64'hDEAD_BEEF_0BAD_F00D;

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;
    logic        spr_req = 0, fix_req = 0, cpu_req = 0, cpu_we = 0;
    logic [24:0] spr_addr = 0, fix_addr = 0, cpu_addr = 0;
    logic [15:0] cpu_din = 0;
    logic [1:0]  cpu_wtbt = 0;
    logic        spr_ack, fix_ack, cpu_ack, err;
    logic [63:0] spr_data, fix_data;
    logic [15:0] cpu_dout;
    logic [24:0] sd_addr;
    logic [15:0] sd_din;
    logic [1:0]  sd_wtbt;
    logic        sd_rd, sd_we;
    logic [63:0] sd_dout = 0;
    logic        sd_ready_first = 0, sd_ready_fourth = 0;

    sdram_arb #(.STARVE_MAX(SM), .TIMEOUT(TO)) dut (
        .clk(clk), .nRESET(nRESET),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_data(spr_data),
        .fix_req(fix_req), .fix_addr(fix_addr), .fix_ack(fix_ack), .fix_data(fix_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_wtbt(cpu_wtbt), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_wtbt(sd_wtbt), .sd_rd(sd_rd), .sd_we(sd_we),
        .sd_dout(sd_dout), .sd_ready_first(sd_ready_first), .sd_ready_fourth(sd_ready_fourth),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] resp(input logic [24:0] a);
        if (a == 25'h100) return 64'h1111_2222_3333_4444;
        return {a[15:0], ~a[15:0], a[24:9], a[15:0] ^ 16'h5A5A};
    endfunction

    // Controller model and scoreboard state
    int          mode = 0;          // 0 normal latency, 1 read hit, 2 never ready
    int          lat_lo = 1, lat_hi = LMAX;
    int          rem = 0, cur_l = 0, cyc = 0, issue_cyc = 0;
    logic [24:0] resp_addr = 0;
    logic        resp_we = 0;
    logic        busy = 0, prev_pulse = 0;
    int          owner = 3;
    int          cpu_wait = 0, snap_wait = 0;
    logic        snap_spr = 0, snap_fix = 0, snap_cpu = 0;
    int          w, exp_w, a_id, nack;
    logic [63:0] ed;
    logic [63:0] exp_spr = 0, exp_fix = 0;
    logic [15:0] exp_cpu = 0;
    logic        exp_err = 0;
    int          starved_grants = 0;
    int          ack_log[$];

    always @(negedge clk) begin
        if (!nRESET) begin
            busy = 0; owner = 3; cpu_wait = 0; prev_pulse = 0; rem = 0;
            snap_spr = 0; snap_fix = 0; snap_cpu = 0; snap_wait = 0;
            exp_spr = 0; exp_fix = 0; exp_cpu = 0; exp_err = 0;
            sd_ready_first = 0; sd_ready_fourth = 0;
        end else begin
            cyc++;
            if (mode == 1) begin
                sd_ready_first = 1; sd_ready_fourth = 1;
            end else if (mode == 2) begin
                sd_ready_first = 0; sd_ready_fourth = 0; sd_dout = NEVER_DATA;
            end
            if (sd_rd || sd_we) begin
                chk("pulse_single", prev_pulse, 0);
                chk("one_outstanding", busy, 0);
                w = int'(sd_addr[24:23]);
                if (snap_cpu && snap_wait >= SM) exp_w = 2;
                else if (snap_spr) exp_w = 0;
                else if (snap_fix) exp_w = 1;
                else exp_w = 2;
                if (exp_w == 2 && snap_spr) starved_grants++;
                chk("winner", w, exp_w);
                case (exp_w)
                    0: chk("req_fields", {sd_addr, sd_din, sd_wtbt, sd_rd, sd_we},
                           {spr_addr, 16'h0, 2'b11, 2'b10});
                    1: chk("req_fields", {sd_addr, sd_din, sd_wtbt, sd_rd, sd_we},
                           {fix_addr, 16'h0, 2'b11, 2'b10});
                    default: chk("req_fields", {sd_addr, sd_din, sd_wtbt, sd_rd, sd_we},
                           {cpu_addr, cpu_din, cpu_wtbt, !cpu_we, cpu_we});
                endcase
                busy = 1; owner = w; issue_cyc = cyc;
                if (w == 2) cpu_wait = 0;
                resp_addr = sd_addr; resp_we = sd_we;
                if (mode == 0) begin
                    cur_l = $urandom_range(lat_hi, lat_lo);
                    rem = cur_l + 2;
                    sd_ready_first = 0; sd_ready_fourth = 0;
                    sd_dout = {$urandom, $urandom};
                end else if (mode == 1) begin
                    cur_l = 1;
                    sd_dout = resp(sd_addr);
                end else begin
                    cur_l = TO + 1;
                end
            end else if (rem > 0) begin
                rem--;
                if (rem == 1 && !resp_we) sd_ready_first = 1;
                if (rem == 0) begin
                    sd_dout = resp(resp_addr);
                    if (resp_we) sd_ready_first = 1;
                    else sd_ready_fourth = 1;
                end
            end
            prev_pulse = sd_rd || sd_we;

            nack = int'(spr_ack) + int'(fix_ack) + int'(cpu_ack);
            if (nack != 0) begin
                chk("ack_onehot", nack, 1);
                a_id = spr_ack ? 0 : (fix_ack ? 1 : 2);
                chk("ack_owner", a_id, owner);
                chk("latency", cyc - issue_cyc, 3 + cur_l);
                ed = (mode == 2) ? NEVER_DATA : resp(resp_addr);
                if (mode == 2) exp_err = 1;
                case (a_id)
                    0: exp_spr = ed;
                    1: exp_fix = ed;
                    default: exp_cpu = ed[63:48];
                endcase
                chk("spr_data", spr_data, exp_spr);
                chk("fix_data", fix_data, exp_fix);
                chk("cpu_dout", cpu_dout, exp_cpu);
                chk("err_at_ack", err, exp_err);
                ack_log.push_back(a_id);
                busy = 0; owner = 3;
            end
            snap_spr = spr_req; snap_fix = fix_req; snap_cpu = cpu_req; snap_wait = cpu_wait;
            if (cpu_req && !(busy && owner == 2) && cpu_wait < SM) cpu_wait++;
        end
    end

    function automatic logic acked(input int id);
        case (id)
            0: return spr_ack;
            1: return fix_ack;
            default: return cpu_ack;
        endcase
    endfunction

    task automatic xfer(input int id, input logic we, input logic [22:0] lo,
                        input logic [15:0] d, input logic [1:0] wt);
        logic [24:0] a;
        int n;
        a = {id[1:0], lo};
        case (id)
            0: begin spr_addr = a; spr_req = 1; end
            1: begin fix_addr = a; fix_req = 1; end
            default: begin
                cpu_addr = a; cpu_we = we; cpu_din = d; cpu_wtbt = wt; cpu_req = 1;
            end
        endcase
        n = 0;
        while (!acked(id) && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 2000) chk("ack_wait", 0, 1);
        case (id)
            0: spr_req = 0;
            1: fix_req = 0;
            default: cpu_req = 0;
        endcase
        @(posedge clk); #2;
    endtask

    logic stop = 0;
    int   c0, n, ack_seen;

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {sd_rd, sd_we, sd_addr, sd_din, sd_wtbt, spr_ack, fix_ack, cpu_ack, err}, 0);
        chk("rst_data", spr_data | fix_data | {48'h0, cpu_dout}, 0);

        // Release reset with a request already pending: grant on the second edge.
        @(posedge clk); #2;
        spr_addr = 25'h100; spr_req = 1;
        nRESET = 1;
        @(negedge clk); @(negedge clk);
        chk("no_grant_edge1", sd_rd, 0);
        @(negedge clk);
        chk("grant_edge2", sd_rd, 1);
        chk("grant_addr", sd_addr, 25'h100);
        n = 0;
        while (!spr_ack && n < 200) begin @(posedge clk); #2; n++; end
        if (n >= 200) chk("ack_wait", 0, 1);
        spr_req = 0;
        @(posedge clk); #2;
        chk("spr_burst", spr_data, 64'h1111_2222_3333_4444);

        // CPU write, fixed latency
        lat_lo = 3; lat_hi = 3;
        xfer(2, 1'b1, 23'h40, 16'hBEEF, 2'b01);

        // Contention: spr, fix, cpu together
        lat_lo = 1; lat_hi = LMAX;
        ack_log.delete();
        fork
            xfer(0, 1'b0, 23'h1234, 16'h0, 2'b00);
            xfer(1, 1'b0, 23'h5678, 16'h0, 2'b00);
            xfer(2, 1'b0, 23'h9ABC, 16'h0, 2'b00);
        join
        chk("order_len", ack_log.size(), 3);
        chk("order_0", ack_log[0], 0);
        chk("order_1", ack_log[1], 1);
        chk("order_2", ack_log[2], 2);

        // Starvation: sprite requests back to back while CPU waits
        stop = 0;
        fork
            begin
                while (!stop) xfer(0, 1'b0, 23'($urandom), 16'h0, 2'b00);
            end
            begin
                repeat (3) begin @(posedge clk); #2; end
                c0 = cyc;
                xfer(2, 1'b0, 23'h777, 16'h0, 2'b00);
                chk("starve_bound", (cyc - c0) <= SM + 2 * (5 + LMAX) + 2, 1);
                stop = 1;
            end
        join
        chk("starved_seen", starved_grants > 0, 1);

        // Randomized traffic from all three clients
        fork
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(3, 0)) begin @(posedge clk); #2; end
                xfer(0, 1'b0, 23'($urandom), 16'h0, 2'b00);
            end
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(3, 0)) begin @(posedge clk); #2; end
                xfer(1, 1'b0, 23'($urandom), 16'h0, 2'b00);
            end
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(3, 0)) begin @(posedge clk); #2; end
                xfer(2, 1'($urandom), 23'($urandom), 16'($urandom), 2'($urandom));
            end
        join

        // Read hit: ready never drops
        mode = 1;
        @(posedge clk); #2;
        xfer(0, 1'b0, 23'h2468, 16'h0, 2'b00);
        xfer(2, 1'b0, 23'h1357, 16'h0, 2'b00);
        chk("hit_err", err, 0);

        // Timeout: ready never rises
        mode = 2;
        @(posedge clk); #2;
        xfer(1, 1'b0, 23'h4242, 16'h0, 2'b00);
        chk("timeout_err", err, 1);
        mode = 0;
        @(posedge clk); #2;
        chk("err_sticky", err, 1);

        // Reset in the middle of ISSUE
        spr_addr = 25'h0000ABC; spr_req = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!sd_rd && n < 100);
        if (n >= 100) chk("issue_wait", 0, 1);
        #1 nRESET = 0;
        #1;
        chk("rst_mid_rd", sd_rd, 0);
        chk("rst_mid_err", err, 0);
        spr_req = 0;
        ack_seen = 0;
        repeat (3) begin @(negedge clk); ack_seen |= int'(spr_ack | fix_ack | cpu_ack); end
        @(posedge clk); #2;
        nRESET = 1;
        repeat (4) begin @(negedge clk); ack_seen |= int'(spr_ack | fix_ack | cpu_ack); end
        chk("rst_no_ack", ack_seen, 0);
        @(posedge clk); #2;
        xfer(0, 1'b0, 23'h0ACE, 16'h0, 2'b00);
        chk("post_rst_err", err, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
